// File: rtl/mandelbrot.sv
// rtl/mandelbrot.sv - Mandelbrot escape-time iterator, one z^2+c step per clock
//
// Iterates z(k+1) = z(k)^2 + c from z(0) = 0 in signed fixed point. Iteration
// stops when |z|^2 > 4.0 or when 255 iterations have been applied. The result
// is reported on count, and done pulses for one cycle when it is valid.
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   rst_n   : asynchronous active-low reset
//   run     : start request, level sensitive, sampled only while idle
//   c_real  : real part of c, signed, Q fractional bits
//   c_imag  : imaginary part of c, signed, Q fractional bits
//   count   : iteration count of the current/last computation
//   done    : one-cycle pulse, count holds the result while high

module mandelbrot #(
  parameter int Q = 12,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [N-1:0] c_real,
  input  logic [N-1:0] c_imag,
  output logic [7:0]   count,
  output logic         done
);

  localparam int W2 = 2 * N + 1;
  // Escape threshold 4.0 in Q format, compared strictly greater-than.
  localparam logic signed [W2-1:0] THRESH = W2'(4 << Q);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [N-1:0]    r_c_re;
  logic signed [N-1:0]    r_c_im;
  logic signed [N-1:0]    r_z_re;
  logic signed [N-1:0]    r_z_im;
  logic [7:0]             r_count;

  logic signed [2*N-1:0]  w_re_x;
  logic signed [2*N-1:0]  w_im_x;
  logic signed [2*N-1:0]  w_re2;
  logic signed [2*N-1:0]  w_im2;
  logic signed [2*N-1:0]  w_reim;
  logic signed [2*N-1:0]  w_diff;
  logic signed [W2-1:0]   w_mag;
  logic signed [N-1:0]    w_z_re_nxt;
  logic signed [N-1:0]    w_z_im_nxt;
  logic                   w_stop;

  // Full-precision products: operands sign-extended to 2N bits first.
  assign w_re_x = {{N{r_z_re[N-1]}}, r_z_re};
  assign w_im_x = {{N{r_z_im[N-1]}}, r_z_im};
  assign w_re2  = w_re_x * w_re_x;
  assign w_im2  = w_im_x * w_im_x;
  assign w_reim = w_re_x * w_im_x;

  // Each square is shifted down to Q format before summing; the extra top
  // bit keeps the sum of two maximal squares from overflowing.
  assign w_mag  = ($signed({w_re2[2*N-1], w_re2}) >>> Q)
                + ($signed({w_im2[2*N-1], w_im2}) >>> Q);

  assign w_stop = (w_mag > THRESH) || (r_count == 8'hFF);

  // Difference taken modulo 2^(2N); only bits [N+Q-1:Q] survive the
  // arithmetic shift-by-Q and truncation to N bits, so no wider sum is needed.
  assign w_diff     = w_re2 - w_im2;
  assign w_z_re_nxt = w_diff[N+Q-1:Q] + r_c_re;
  // (2*re*im) >>> Q truncated to N bits is re*im bits [N+Q-2:Q-1].
  assign w_z_im_nxt = w_reim[N+Q-2:Q-1] + r_c_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        if (w_stop) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_re  <= '0;
      r_c_im  <= '0;
      r_z_re  <= '0;
      r_z_im  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // c is captured here so later input changes cannot disturb the run.
          if (run) begin
            r_c_re  <= c_real;
            r_c_im  <= c_imag;
            r_z_re  <= '0;
            r_z_im  <= '0;
            r_count <= '0;
          end
        end
        S_ITER: begin
          if (!w_stop) begin
            r_z_re  <= w_z_re_nxt;
            r_z_im  <= w_z_im_nxt;
            r_count <= r_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_mandelbrot.sv
// tb/tb_mandelbrot.sv - self-checking bench for mandelbrot against an arithmetic model

module tb_mandelbrot;

  localparam int Q = 12;
  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] c_real;
  logic [15:0] c_imag;
  logic [7:0]  count;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  mandelbrot #(.Q(Q), .N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .c_real (c_real),
    .c_imag (c_imag),
    .count  (count),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  // Escape-time count computed with plain integer arithmetic on real values
  // scaled by 2^Q.
  function automatic int model_count(input logic [15:0] cr, input logic [15:0] ci);
    longint zr, zi, re2, im2, mag, cre, cim, nr, ni;
    cre = longint'($signed(cr));
    cim = longint'($signed(ci));
    zr = 0;
    zi = 0;
    for (int k = 0; k < 256; k++) begin
      re2 = zr * zr;
      im2 = zi * zi;
      mag = (re2 >>> Q) + (im2 >>> Q);
      if (mag > (longint'(4) << Q) || k == 255) return k;
      nr = ((re2 - im2) >>> Q) + cre;
      ni = ((2 * zr * zi) >>> Q) + cim;
      zr = wrap16(nr);
      zi = wrap16(ni);
    end
    return 255;
  endfunction

  // One computation with a single-cycle run request; lat counts negedges
  // from the drive edge to the first done observation.
  task automatic do_run(input logic [15:0] cr, input logic [15:0] ci,
                        output int cnt, output int lat);
    @(negedge clk);
    c_real = cr;
    c_imag = ci;
    run    = 1'b1;
    cnt    = -1;
    lat    = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done) begin
        cnt = int'(count);
        lat = i;
        break;
      end
      run = 1'b0;
    end
    run = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] cr,
                               input logic [15:0] ci, input int exp_cnt);
    int cnt, lat;
    do_run(cr, ci, cnt, lat);
    check({tag, "_count"}, cnt, exp_cnt);
    check({tag, "_latency"}, lat, exp_cnt + 2);
  endtask

  initial begin
    int pulses, first_i, second_i, lat, cnt, got_cnt;
    logic [15:0] cr, ci;

    rst_n  = 1'b0;
    run    = 1'b0;
    c_real = '0;
    c_imag = '0;
    repeat (3) @(negedge clk);
    check("reset_count", count, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", done, 0);

    // Directed boundary points.
    run_and_check("c_2p0", 16'h2000, 16'h0000, 2);
    run_and_check("c_1p1i", 16'h1000, 16'h1000, 2);
    run_and_check("c_m2p0", 16'hE000, 16'h0000, 255);
    run_and_check("c_zero", 16'h0000, 16'h0000, 255);

    // Held run: back-to-back non-escaping computations 258 cycles apart.
    @(negedge clk);
    c_real = 16'h0030;
    c_imag = 16'h0030;
    run    = 1'b1;
    pulses = 0;
    first_i = -1;
    second_i = -1;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("held_count", count, 255);
        if (pulses == 1) first_i = i;
        else begin
          second_i = i;
          run = 1'b0;
          break;
        end
      end
    end
    run = 1'b0;
    check("held_first_latency", first_i, 257);
    check("held_period", second_i - first_i, 258);

    // Reset in the middle of ITER aborts without a done pulse.
    @(negedge clk);
    c_real = 16'h0030;
    c_imag = 16'h0030;
    run    = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 101; i++) begin
      @(negedge clk);
      if (done) pulses++;
      if (i == 100) check("iter_count_mid", count, 99);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_done", done, 0);
    check("no_pulse_before_reset", pulses, 0);
    @(negedge clk);
    check("reset_hold_count", count, 0);
    rst_n = 1'b1;
    run   = 1'b1;
    lat   = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        got_cnt = int'(count);
        run = 1'b0;
        break;
      end
    end
    run = 1'b0;
    check("post_reset_latency", lat, 257);
    check("post_reset_count", got_cnt, 255);

    // Inputs scrambled and run dropped mid-computation.
    @(negedge clk);
    c_real = 16'h0030;
    c_imag = 16'h0030;
    run    = 1'b1;
    pulses = 0;
    lat    = -1;
    got_cnt = -1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          lat = i;
          got_cnt = int'(count);
        end
      end
      c_real = 16'($urandom);
      c_imag = 16'($urandom);
      if (i == 50) run = 1'b0;
    end
    check("scramble_pulses", pulses, 1);
    check("scramble_count", got_cnt, 255);
    check("scramble_latency", lat, 257);

    // Randomized points, mostly near the set boundary, some full range.
    for (int t = 0; t < 24; t++) begin
      if (t < 18) begin
        cr = 16'(int'($urandom_range(0, 32'h5000)) - 32'h2800);
        ci = 16'(int'($urandom_range(0, 32'h3000)) - 32'h1800);
      end else begin
        cr = 16'($urandom);
        ci = 16'($urandom);
      end
      cnt = model_count(cr, ci);
      run_and_check($sformatf("rand%0d", t), cr, ci, cnt);
    end

    repeat (5) @(negedge clk);
    check("final_idle_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot.md
MANDELBROT -- requirements
Module: mandelbrot

Interface
REQ-001 Parameter Q, default 12, number of fractional bits of the signed fixed-point format.
REQ-002 Parameter N, default 16, total width of every fixed-point operand (two's complement, Q fractional bits).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 run  input  1  start request, level-sensitive, sampled only in IDLE.
REQ-006 c_real  input  N  real part of point c, signed Q-format.
REQ-007 c_imag  input  N  imaginary part of point c, signed Q-format.
REQ-008 count  output  8  iteration count of the current/last computation (register).
REQ-009 done  output  1  one-cycle pulse marking a valid result on count.

Function
REQ-010 The module SHALL iterate z(k+1) = z(k)^2 + c from z(0) = 0, one iteration per clock, with a 3-state FSM: IDLE, ITER, DONE.
REQ-011 IDLE: done=0; if run=1, latch c_real/c_imag into internal registers, clear z_re, z_im and count to 0, go to ITER; else stay.
REQ-012 ITER, each cycle: compute mag = z_re^2 + z_im^2 from the current z; if mag > 4.0 or count == 255, go to DONE with z and count unchanged; else z <= z^2 + c_latched, count <= count+1.
REQ-013 DONE: done=1 for exactly this one cycle; count holds; next state IDLE unconditionally.
REQ-014 Products SHALL be computed at full 2N-bit signed precision, then arithmetically shifted right by Q.
REQ-015 New z_re = (z_re^2 - z_im^2)>>Q + c_re; new z_im = (2*z_re*z_im)>>Q + c_im; both truncated to N bits (wrap, no saturation).
REQ-016 The escape comparison SHALL use at least N+2 bits so that mag cannot overflow for |z_re|,|z_im| < 2^(N-1-Q); threshold constant = 4<<Q; comparison strictly greater-than.
REQ-017 c_real/c_imag changes after latching SHALL NOT affect a running computation; run deassertion during ITER/DONE is ignored (computation completes).
REQ-018 With run held high, a new computation SHALL start on the cycle after DONE (IDLE lasts one cycle), so done pulses repeat.
REQ-019 Latency from the run-sampling IDLE edge to the done pulse = 1 + (count+1) ITER cycles; non-escaping point: 258 cycles per computation (IDLE + 256 ITER + DONE).
REQ-020 count visibly increments during ITER; it is valid only while done=1 and retains its value until the next start.
REQ-021 Results for |c| > 2 are defined only by REQ-015 wrap rules; no error flag.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, done=0, count=0, z_re=z_im=0, latched c=0.
REQ-023 Reset asserted mid-ITER or in DONE SHALL abort the computation with no done pulse; after release the FSM waits in IDLE for run.
REQ-024 First start after release needs run=1 sampled on a rising edge with rst_n=1.

Verification
REQ-025 c=(0x0030,0x0030) (~0.0117+0.0117i), run held 1 -> done pulses with count=255, second pulse exactly 258 cycles after first.
REQ-026 c=(0x2000,0x0000) (2.0) -> done with count=2 (z=2, |z|^2=4 not >4, then z=6 escapes).
REQ-027 c=(0x1000,0x1000) (1+1i) -> done with count=2.
REQ-028 c=(0xE000,0x0000) (-2.0) -> count=255 (orbit -2,2,2,... never strictly exceeds 4).
REQ-029 Start c=0x0030 pair, pulse rst_n low at cycle 100 of ITER -> done never pulses, count=0 immediately; after release with run=1 a full 258-cycle computation completes.
REQ-030 Change c_real every cycle during ITER, drop run mid-ITER -> result identical to stable-input run; single done pulse, then module stays in IDLE.
